trainled_chain: RTL and testbench

//  Parametrised daisy-chain LED node for the TrainLED family: NCH channels, BITS-bit duty words.

---
 rtl/trainled_chain.sv | 143 ++++++++++++++
 tb/tb_trainled_chain.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/trainled_chain.sv
// trainled_chain: self-clocked daisy-chain LED node with PWM + sigma-delta drive; TRAINLED_GAMMA_EN squares committed words
module trainled_chain #(
  parameter int NCH         = 3,
  parameter int BITS        = 8,
  parameter int PWM_BITS    = 4,
  parameter int BIT_TICKS   = 12,
  parameter int SAMPLE_TICK = 6,
  parameter int RESET_TICKS = 96
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           din,
  output logic           dout,
  output logic [NCH-1:0] led,
  output logic           load_stb
);
  localparam int NB   = NCH * BITS;
  localparam int FRAC = BITS - PWM_BITS;
  localparam int TW   = $clog2(BIT_TICKS);
  localparam int CW   = $clog2(NB + 1);
  localparam int GW   = $clog2(RESET_TICKS + 1);

  typedef enum logic [1:0] {LATCH, RECV, FWD} state_t;

  state_t              state_q;
  logic [TW-1:0]       tick_q, tick_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [CW-1:0]       bitcnt_q;
  logic [NB-1:0]       shreg_q, frame_q, duty_q, word_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic                pend_q, pend_d, load_q, dout_q;
  logic                sample, gap_hit, full, commit;

  // slot timing, din-low gap tracking and commit qualification
  always_comb begin
    tick_d  = (tick_q == '0 || tick_q == TW'(BIT_TICKS - 1)) ? {{(TW-1){1'b0}}, din} : tick_q + TW'(1);
    gap_d   = din ? '0 : (gap_q == GW'(RESET_TICKS)) ? gap_q : gap_q + GW'(1);
    sample  = tick_q == TW'(SAMPLE_TICK);
    gap_hit = !din && gap_q == GW'(RESET_TICKS - 1);
    full    = bitcnt_q == CW'(NB);
    commit  = pwm_q == '1 && pend_q;
    pend_d  = (gap_hit && full) || (pend_q && !commit);
  end

  // each received word is optionally gamma-squared on its way into the frame buffer
  for (genvar i = 0; i < NCH; i++) begin : g_word
`ifdef TRAINLED_GAMMA_EN
    logic [2*BITS-1:0] w2, sq;
    assign w2 = {{BITS{1'b0}}, shreg_q[i*BITS +: BITS]};
    assign sq = w2 * w2;
    assign word_d[i*BITS +: BITS] = BITS'(sq >> BITS);
`else
    assign word_d[i*BITS +: BITS] = shreg_q[i*BITS +: BITS];
`endif
  end

  // slot counter and gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      gap_q  <= '0;
    end else begin
      tick_q <= tick_d;
      gap_q  <= gap_d;
    end
  end

  // receive / forward state machine; a long gap latches a complete frame and restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LATCH;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      frame_q  <= '0;
      dout_q   <= 1'b0;
    end else if (gap_hit) begin
      state_q  <= LATCH;
      bitcnt_q <= '0;
      dout_q   <= 1'b0;
      if (full) frame_q <= word_d;
    end else begin
      case (state_q)
        LATCH: begin
          dout_q <= 1'b0;
          if (din) state_q <= RECV;
        end
        RECV: begin
          dout_q <= 1'b0;
          if (sample) begin
            shreg_q  <= {shreg_q[NB-2:0], din};
            bitcnt_q <= bitcnt_q + CW'(1);
            if (bitcnt_q == CW'(NB - 1)) state_q <= FWD;
          end
        end
        FWD: dout_q <= (tick_q == TW'(2)) ? 1'b1 : sample ? din : (tick_q == TW'(BIT_TICKS - 2)) ? 1'b0 : dout_q;
        default: state_q <= LATCH;
      endcase
    end
  end

  // free-running PWM counter; pending frames move into the duty latches on counter wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= '0;
      pend_q <= 1'b0;
      load_q <= 1'b0;
      duty_q <= '0;
    end else begin
      pwm_q  <= pwm_q + PWM_BITS'(1);
      pend_q <= pend_d;
      load_q <= commit;
      if (commit) duty_q <= frame_q;
    end
  end

  // per channel: coarse PWM on the high bits, first-order sigma-delta carry on the low bits
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [BITS-1:0] w;
    logic [FRAC-1:0] acc_q;
    logic [FRAC:0]   sum;
    logic            led_q;
    assign w   = duty_q[(NCH-k)*BITS-1 -: BITS];
    assign sum = {1'b0, acc_q} + {1'b0, w[FRAC-1:0]};
    // all-ones tick emits the carry; otherwise the coarse compare ends the pulse and zero starts it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        led_q <= 1'b0;
      end else if (pwm_q == '1) begin
        acc_q <= sum[FRAC-1:0];
        led_q <= sum[FRAC];
      end else if (pwm_q == w[BITS-1:FRAC]) begin
        led_q <= 1'b0;
      end else if (pwm_q == '0) begin
        led_q <= 1'b1;
      end
    end
    assign led[k] = led_q;
  end

  assign dout     = dout_q;
  assign load_stb = load_q;
endmodule

// File: tb/tb_trainled_chain.sv
// tb_trainled_chain: directed vector bench for trainled_chain
module tb_trainled_chain;
  localparam int NCH = 3;

  typedef struct {
    logic [47:0] data;
    int          nbits;
    int          gap;
    int          loads;
    logic [23:0] duty;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           din = 1'b0;
  logic           dout, load_stb;
  logic [NCH-1:0] led;

  int          nvec = 0, nerr = 0, load_total = 0, base, early_hi;
  int          hi[NCH];
  logic [23:0] cap_pre, cap_hi, cap_d6, cap_d9, cap_lo;
  vec_t        tbl[4];

  trainled_chain dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .led(led), .load_stb(load_stb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_stb) load_total++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  // one bit slot: high for ticks 0-3, data for 4-8, low for 9-11
  task automatic send_bit(input logic b, input int idx);
    for (int c = 0; c < 12; c++) begin
      cyc((c < 4) ? 1'b1 : (c < 9) ? b : 1'b0);
      if (idx < 24) begin
        if (dout) early_hi++;
      end else begin
        if (c == 1)  cap_pre[47-idx] = dout;
        if (c == 2)  cap_hi[47-idx]  = dout;
        if (c == 6)  cap_d6[47-idx]  = dout;
        if (c == 9)  cap_d9[47-idx]  = dout;
        if (c == 10) cap_lo[47-idx]  = dout;
      end
    end
  endtask

  task automatic send_bits(input logic [47:0] data, input int n, input int first);
    for (int i = 0; i < n; i++) send_bit(data[n-1-i], first + i);
  endtask

  task automatic measure(input int n);
    for (int k = 0; k < NCH; k++) hi[k] = 0;
    for (int c = 0; c < n; c++) begin
      cyc(1'b0);
      for (int k = 0; k < NCH; k++) if (led[k]) hi[k]++;
    end
  endtask

  // over 256 cycles a channel is high for exactly 16*coarse+frac = duty cycles
  task automatic chk_duty(input string name, input logic [23:0] duty);
    logic [23:0] d;
    d = duty;
    measure(256);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("%s_ch%0d", name, k), hi[k], {24'd0, d[(2-k)*8 +: 8]});
  endtask

  initial begin
    int bad;
`ifdef TRAINLED_GAMMA_EN
    tbl[0] = '{48'hFF8000,       24, 100, 1, 24'hFE4000};
    tbl[1] = '{48'h010203AABBCC, 48, 100, 1, 24'h000000};
    tbl[2] = '{48'hABC,          12, 100, 0, 24'h000000};
    tbl[3] = '{48'h1940FF,       24, 100, 1, 24'h0210FE};
`else
    tbl[0] = '{48'hFF8000,       24, 100, 1, 24'hFF8000};
    tbl[1] = '{48'h010203AABBCC, 48, 100, 1, 24'h010203};
    tbl[2] = '{48'hABC,          12, 100, 0, 24'h010203};
    tbl[3] = '{48'h1940FF,       24, 100, 1, 24'h1940FF};
`endif

    bad = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(i[0]);
      if (dout || led != '0 || load_stb) bad++;
    end
    chk("reset_outputs", bad, 0);
    rst_n = 1'b1;
    measure(32);
    chk("reset_led_idle", hi[0] + hi[1] + hi[2], 0);

    for (int v = 0; v < 4; v++) begin
      early_hi = 0;
      cap_pre = '0; cap_hi = '0; cap_d6 = '0; cap_d9 = '0; cap_lo = '0;
      base = load_total;
      send_bits(tbl[v].data, tbl[v].nbits, 0);
      idle(tbl[v].gap + 40);
      chk($sformatf("v%0d_loads", v), load_total - base, tbl[v].loads);
      chk($sformatf("v%0d_dout_recv", v), early_hi, 0);
      chk_duty($sformatf("v%0d", v), tbl[v].duty);
      if (tbl[v].nbits == 48) begin
        chk("fwd_pre", cap_pre, 24'h000000);
        chk("fwd_hi",  cap_hi,  24'hFFFFFF);
        chk("fwd_d6",  cap_d6,  24'hAABBCC);
        chk("fwd_d9",  cap_d9,  24'hAABBCC);
        chk("fwd_lo",  cap_lo,  24'h000000);
      end
    end

    base = load_total;
    send_bits(48'h123, 12, 0);
    idle(92);
    send_bits(48'h456, 12, 12);
    idle(140);
    chk("gap95_loads", load_total - base, 1);
`ifdef TRAINLED_GAMMA_EN
    chk_duty("gap95", 24'h010A1C);
`else
    chk_duty("gap95", 24'h123456);
`endif

    base = load_total;
    send_bits(48'h123, 12, 0);
    idle(93);
    send_bits(48'h456, 12, 12);
    idle(140);
    chk("gap96_loads", load_total - base, 0);
`ifdef TRAINLED_GAMMA_EN
    chk_duty("gap96", 24'h010A1C);
`else
    chk_duty("gap96", 24'h123456);
`endif

    send_bits(48'h123, 12, 0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    base = load_total;
    send_bits(48'h456, 12, 12);
    idle(140);
    chk("midreset_loads", load_total - base, 0);
    chk_duty("midreset", 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
